mux3_rr_sequencer: RTL and testbench

Round-robin sequencer that shares one 3:1 operand mux, and the single add/sub datapath stage behind it, between three requesters in the FP add/sub unit. It arbitrates the requests and drives the mux select. It registers the selected operand and holds the grant until the downstream stage signals completion or a timeout expires. It replaces the hard-wired select lines that previously drove the mux from separate control paths.

---
 rtl/mux3_rr_sequencer.sv | 153 +++++++++++++++
 tb/tb_mux3_rr_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mux3_rr_sequencer.sv
// -----------------------------------------------------------------------------
// mux3_rr_sequencer
//
// Round-robin sequencer that shares one 3:1 operand mux, and the add/sub stage
// behind it, between three requesters. It picks a winner, drives the mux
// select, registers the selected operand and holds the grant until the
// downstream stage reports done or the timeout expires.
//
// Parameters
//   W    operand width in bits
//   TMO  maximum WAIT cycles before the grant is forcibly released (0 = never)
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   req[2:0]  request vector, bit i = requester i
//   D0/D1/D2  operands from requesters 0/1/2
//   done      completion pulse from the shared datapath stage
//   gnt[2:0]  one-hot grant, 000 when idle
//   ctrl[1:0] mux select, 00/01/10 while granted, 11 when idle
//   S         registered selected operand
//   load      one-cycle pulse when S is newly valid
//   busy      high while a grant is held
//   err       one-cycle pulse after a timeout abort
// -----------------------------------------------------------------------------
module mux3_rr_sequencer #(
  parameter int W   = 8,
  parameter int TMO = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   req,
  input  logic [W-1:0] D0,
  input  logic [W-1:0] D1,
  input  logic [W-1:0] D2,
  input  logic         done,
  output logic [2:0]   gnt,
  output logic [1:0]   ctrl,
  output logic [W-1:0] S,
  output logic         load,
  output logic         busy,
  output logic         err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // Counter only has to reach TMO-1; keep at least one bit so TMO of 0 or 1
  // still elaborates.
  localparam int            CW       = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);
  localparam logic [1:0]    SEL_IDLE = 2'b11;

  logic [0:0]    state_q, state_d;
  logic [2:0]    gnt_q,   gnt_d;
  logic [1:0]    ctrl_q,  ctrl_d;
  logic [W-1:0]  s_q,     s_d;
  logic          load_q,  load_d;
  logic          err_q,   err_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [1:0]    last_q,  last_d;

  logic [1:0]    win;
  logic [W-1:0]  win_data;

  // Winner: first set request bit scanning upward from last+1, wrapping mod 3.
  always_comb begin
    win = 2'd0;
    case (last_q)
      2'd0:    win = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    win = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: win = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  // Shared operand mux; select 11 yields the default output of zero.
  always_comb begin
    case (win)
      2'd0:    win_data = D0;
      2'd1:    win_data = D1;
      2'd2:    win_data = D2;
      default: win_data = '0;
    endcase
  end

  always_comb begin
    // NOTE: every next-state signal defaults to "hold" first, so no path
    // through the branches below leaves one unassigned and infers a latch.
    state_d = state_q;
    gnt_d   = gnt_q;
    ctrl_d  = ctrl_q;
    s_d     = s_q;
    load_d  = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    last_d  = last_q;

    if (state_q == ST_IDLE) begin
      if (|req) begin
        state_d = ST_WAIT;
        gnt_d   = 3'b001 << win;
        ctrl_d  = win;
        s_d     = win_data;
        load_d  = 1'b1;
        cnt_d   = '0;
      end
    end else begin
      // done has priority over the timeout; a timeout also rotates priority
      // so a stalled requester does not starve the others.
      if (done || (TMO != 0 && cnt_q == CNT_LAST)) begin
        state_d = ST_IDLE;
        gnt_d   = 3'b000;
        ctrl_d  = SEL_IDLE;
        last_d  = ctrl_q;
        err_d   = ~done;
      end else if (cnt_q != {CW{1'b1}}) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= 3'b000;
      ctrl_q  <= SEL_IDLE;
      s_q     <= '0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      last_q  <= 2'd2;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ctrl_q  <= ctrl_d;
      s_q     <= s_d;
      load_q  <= load_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign gnt  = gnt_q;
  assign ctrl = ctrl_q;
  assign S    = s_q;
  assign load = load_q;
  assign busy = (state_q == ST_WAIT);
  assign err  = err_q;

endmodule

// File: tb/tb_mux3_rr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mux3_rr_sequencer
//
// Self-checking bench: directed scenarios followed by randomized traffic,
// all compared against a transaction-level reference model of the sequencer.
// -----------------------------------------------------------------------------
module tb_mux3_rr_sequencer;

  localparam int W   = 8;
  localparam int TMO = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [2:0]   req = 3'b000;
  logic [W-1:0] d0 = '0, d1 = '0, d2 = '0;
  logic         done = 1'b0;
  logic [2:0]   gnt;
  logic [1:0]   ctrl;
  logic [W-1:0] s;
  logic         load, busy, err;

  int total = 0;
  int bad   = 0;

  // Reference model: who holds the grant, who was served last, how long the
  // current grant has waited.
  bit           m_busy;
  int           m_win, m_last, m_wait;
  logic [W-1:0] m_s;
  bit           m_load, m_err;

  mux3_rr_sequencer #(.W(W), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .D0(d0), .D1(d1), .D2(d2), .done(done),
    .gnt(gnt), .ctrl(ctrl), .S(s), .load(load), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_busy = 0; m_win = 0; m_last = 2; m_wait = 0;
    m_s = '0; m_load = 0; m_err = 0;
  endfunction

  // One clock edge of the specified behaviour, using the inputs seen at it.
  function automatic void model_edge(input logic [2:0] r, input logic dn,
                                     input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [W-1:0] c);
    logic [W-1:0] ops [3];
    ops[0] = a; ops[1] = b; ops[2] = c;
    m_load = 0;
    m_err  = 0;
    if (!m_busy) begin
      if (r != 3'b000) begin
        for (int k = 1; k <= 3; k++) begin
          if (r[(m_last + k) % 3]) begin
            m_win = (m_last + k) % 3;
            break;
          end
        end
        m_busy = 1; m_s = ops[m_win]; m_load = 1; m_wait = 0;
      end
    end else if (dn) begin
      m_busy = 0; m_last = m_win;
    end else if (m_wait + 1 >= TMO) begin
      m_busy = 0; m_last = m_win; m_err = 1;
    end else begin
      m_wait++;
    end
  endfunction

  task automatic check_all();
    check("gnt",  gnt,  m_busy ? (32'd1 << m_win) : 32'd0);
    check("ctrl", ctrl, m_busy ? m_win : 32'd3);
    check("S",    s,    m_s);
    check("load", load, m_load);
    check("busy", busy, m_busy);
    check("err",  err,  m_err);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(req, done, d0, d1, d2);
    #1;
    check_all();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    rst = 1'b0;
    #2;
    model_reset();
    check("rst_gnt",  gnt,  32'd0);
    check("rst_ctrl", ctrl, 32'd3);
    check("rst_S",    s,    32'd0);
    check_all();
    rst = 1'b1;
  endtask

  int exp_order [4] = '{0, 1, 2, 0};

  initial begin
    model_reset();
    #7;
    do_reset();

    // First grant after reset goes to requester 0 with its operand.
    req = 3'b001; d0 = 8'h3C;
    step();
    check("t1_gnt", gnt, 32'b001);
    check("t1_S",   s,   32'h3C);
    check("t1_load", load, 32'd1);
    req = 3'b000; done = 1'b1;
    step();
    check("t1_rel_ctrl", ctrl, 32'd3);
    done = 1'b0;

    // All three requesting: rotation 0,1,2,0 with one idle cycle between.
    #2; do_reset();
    req = 3'b111; d0 = 8'h10; d1 = 8'h20; d2 = 8'h30;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_ctrl", ctrl, exp_order[i]);
      step();
      done = 1'b1;
      step();
      check("rr_idle_busy", busy, 32'd0);
      done = 1'b0;
    end

    // Requester 1 wins after 0; operand is frozen while granted.
    req = 3'b110; d1 = 8'h11;
    step();
    check("t3_gnt", gnt, 32'b010);
    d1 = 8'hFF;
    step(); step();
    check("t3_S_hold", s, 32'h11);
    done = 1'b1; step(); done = 1'b0;

    // Timeout on requester 2, then requester 0 wins on req=101.
    req = 3'b100; d2 = 8'hA5;
    step();
    check("t4_gnt", gnt, 32'b100);
    req = 3'b000;
    for (int i = 0; i < TMO; i++) step();
    check("t4_err",  err,  32'd1);
    check("t4_busy", busy, 32'd0);
    step();
    check("t4_err_clr", err, 32'd0);
    req = 3'b101; d0 = 8'h5A;
    step();
    check("t4_next", gnt, 32'b001);

    // done on the timeout edge: release without err.
    req = 3'b000;
    for (int i = 0; i < TMO - 1; i++) step();
    done = 1'b1;
    step();
    check("t5_err", err, 32'd0);
    check("t5_gnt", gnt, 32'd0);
    // done while idle is ignored.
    step();
    done = 1'b0;
    step();
    check("t5_idle", busy, 32'd0);

    // Reset mid-WAIT with requester 1 granted.
    req = 3'b010; d1 = 8'h77;
    step();
    check("t6_gnt", gnt, 32'b010);
    req = 3'b000;
    step();
    #2; do_reset();
    req = 3'b111;
    step();
    check("t6_after", gnt, 32'b001);
    done = 1'b1; step(); done = 1'b0;

    // Randomized traffic, with occasional asynchronous resets.
    for (int i = 0; i < 1500; i++) begin
      req  = 3'($urandom_range(0, 7));
      done = ($urandom_range(0, 3) == 0);
      d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #2; do_reset();
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
